// File: rtl/wb_stream_writer.sv
// rtl/wb_stream_writer.sv - stream-to-Wishbone single-write front end for the dual-port BRAM
// Optional bus watchdog is compiled in when WB_STREAM_WRITER_TIMEOUT_EN is defined.
module wb_stream_writer #(
  parameter int DW      = 8,
  parameter int AW      = 10,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_clear,
  input  logic            i_valid,
  input  logic [DW-1:0]   i_data,
  output logic            o_ready,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  output logic [15:0]     o_count,
  output logic            o_wrapped,
  output logic            o_err,
  output logic            o_busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_q;
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   ptr_d;
  logic            wrap_d;
  logic [15:0]     count_q;
  logic [15:0]     count_d;
  logic            cyc_q;
  logic            stb_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            wrapped_q;
  logic            err_q;
  logic            busy_q;
  logic            tmo_hit;

  assign wrap_d  = (ptr_q == LAST_ADDR);
  assign ptr_d   = wrap_d ? '0 : ptr_q + AW'(1);
  assign count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

`ifdef WB_STREAM_WRITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q;

  // Counts cycles spent on the bus; hits on the cycle it would reach TIMEOUT.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
  // Watchdog absent: never fires, the block waits for ack/err indefinitely.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      count_q   <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_clear) begin
            ptr_q     <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            err_q     <= 1'b0;
          end else if (i_valid) begin
            addr_q  <= ptr_q;
            data_q  <= i_data;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (tmo_hit) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (!i_wb_stall) begin
            stb_q   <= 1'b0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // err beats ack, and a real response beats the watchdog.
          if (i_wb_err) begin
            err_q   <= 1'b1;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (i_wb_ack) begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (wrap_d) begin
              wrapped_q <= 1'b1;
            end
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready   = (state_q == IDLE) && !i_clear;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;
  assign o_wb_sel  = '1;
  assign o_count   = count_q;
  assign o_wrapped = wrapped_q;
  assign o_err     = err_q;
  assign o_busy    = busy_q;

endmodule
